// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock/tick divider.
package clk_div_pkg;

  localparam int CW_DEF      = 32;
  localparam int NCH_MAX     = 16;
  localparam int DEF_DIV_DEF = 50000000;

  // A zero half-period has no meaning; it is promoted to the fastest rate.
  function automatic logic [63:0] sat_div(input logic [63:0] v);
    return (v == 64'd0) ? 64'd1 : v;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active/shadow half-period, busy flag,
// registered 50%-duty level and one-cycle toggle strobe.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int          CW      = CW_DEF,
  parameter int unsigned DEF_DIV = DEF_DIV_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          wr,
  input  logic [CW-1:0] wr_val,
  input  logic          sync,
  output logic          clk_out,
  output logic          tick,
  output logic          busy
);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_act;
  logic [CW-1:0] r_shadow;
  logic          r_busy;
  logic          r_clk_out;
  logic          r_tick;
  logic          w_wrap;

  // r_act never reaches zero, and r_cnt < r_act always holds.
  assign w_wrap = (r_cnt == r_act - CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_act     <= CW'(DEF_DIV);
      r_shadow  <= CW'(DEF_DIV);
      r_busy    <= 1'b0;
      r_clk_out <= 1'b0;
      r_tick    <= 1'b0;
    end else if (!en) begin
      r_cnt     <= '0;
      r_clk_out <= 1'b0;
      r_tick    <= 1'b0;
      r_busy    <= 1'b0;
      if (wr) begin
        r_act    <= wr_val;
        r_shadow <= wr_val;
      end else if (r_busy) begin
        r_act <= r_shadow;
      end
    end else begin
      if (sync) begin
        r_cnt     <= '0;
        r_clk_out <= 1'b0;
        r_tick    <= 1'b0;
        if (r_busy) r_act <= r_shadow;
      end else if (w_wrap) begin
        r_cnt     <= '0;
        r_clk_out <= ~r_clk_out;
        r_tick    <= 1'b1;
        if (r_busy) r_act <= r_shadow;
      end else begin
        r_cnt  <= r_cnt + CW'(1);
        r_tick <= 1'b0;
      end
      // A write in the same cycle as a wrap/sync stays pending for the next one.
      if (wr) begin
        r_shadow <= wr_val;
        r_busy   <= 1'b1;
      end else if (sync || w_wrap) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign clk_out = r_clk_out;
  assign tick    = r_tick;
  assign busy    = r_busy;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel clock/tick divider: decodes divisor writes and broadcasts
// sync to NCH independent clk_div_chan instances.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int          NCH     = 4,
  parameter int          CW      = CW_DEF,
  parameter int unsigned DEF_DIV = DEF_DIV_DEF,
  localparam int         CHW     = $clog2(NCH) | 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [NCH-1:0] en,
  input  logic           div_wr,
  input  logic [CHW-1:0] div_ch,
  input  logic [CW-1:0]  div_val,
  input  logic           sync,
  output logic [NCH-1:0] clk_out,
  output logic [NCH-1:0] tick,
  output logic [NCH-1:0] busy
);

  logic [CW-1:0]  w_div_sat;
  logic [NCH-1:0] w_wr;

  assign w_div_sat = CW'(sat_div(64'(div_val)));

  // Out-of-range channel numbers match no instance and are dropped.
  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_chan
      assign w_wr[gi] = div_wr && (div_ch == CHW'(gi));

      clk_div_chan #(
        .CW      (CW),
        .DEF_DIV (DEF_DIV)
      ) u_chan (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en[gi]),
        .wr      (w_wr[gi]),
        .wr_val  (w_div_sat),
        .sync    (sync),
        .clk_out (clk_out[gi]),
        .tick    (tick[gi]),
        .busy    (busy[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi: directed scenarios with literal
// expectations plus a randomized run against a deadline-based reference model.
module tb_clk_div_multi;

  localparam int NCH  = 4;
  localparam int CW   = 32;
  localparam int DEFD = 10;
  localparam int CHW  = 3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [NCH-1:0] en = '0;
  logic           div_wr = 1'b0;
  logic [CHW-1:0] div_ch = '0;
  logic [CW-1:0]  div_val = '0;
  logic           sync = 1'b0;
  logic [NCH-1:0] clk_out;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] busy;

  always #5 clk = ~clk;

  clk_div_multi #(
    .NCH     (NCH),
    .CW      (CW),
    .DEF_DIV (DEFD)
  ) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .div_wr  (div_wr),
    .div_ch  (div_ch),
    .div_val (div_val),
    .sync    (sync),
    .clk_out (clk_out),
    .tick    (tick),
    .busy    (busy)
  );

  int vec_cnt = 0;
  int mis_cnt = 0;
  bit chk_on  = 1'b0;

  // Reference model: each running channel holds the absolute edge number of its next toggle.
  longint t_now;
  longint m_act  [NCH];
  longint m_pend [NCH];
  longint m_next [NCH];
  bit     m_flag [NCH];
  bit     m_run  [NCH];
  bit     m_out  [NCH];
  bit     m_tick [NCH];

  function automatic void model_reset();
    t_now = 0;
    for (int i = 0; i < NCH; i++) begin
      m_act[i]  = DEFD;
      m_pend[i] = DEFD;
      m_next[i] = 0;
      m_flag[i] = 1'b0;
      m_run[i]  = 1'b0;
      m_out[i]  = 1'b0;
      m_tick[i] = 1'b0;
    end
  endfunction

  function automatic void model_step();
    longint val;
    bit     wr;
    t_now++;
    val = (div_val == '0) ? 1 : longint'(div_val);
    for (int i = 0; i < NCH; i++) begin
      wr = div_wr && (int'(div_ch) == i);
      if (!en[i]) begin
        m_run[i]  = 1'b0;
        m_out[i]  = 1'b0;
        m_tick[i] = 1'b0;
        if (m_flag[i]) m_act[i] = m_pend[i];
        m_flag[i] = 1'b0;
        if (wr) begin
          m_act[i]  = val;
          m_pend[i] = val;
        end
      end else begin
        m_tick[i] = 1'b0;
        if (sync) begin
          m_run[i] = 1'b1;
          m_out[i] = 1'b0;
          if (m_flag[i]) m_act[i] = m_pend[i];
          m_flag[i] = 1'b0;
          m_next[i] = t_now + m_act[i];
        end else begin
          if (!m_run[i]) begin
            m_run[i]  = 1'b1;
            m_next[i] = t_now + m_act[i] - 1;
          end
          if (t_now == m_next[i]) begin
            m_out[i]  = ~m_out[i];
            m_tick[i] = 1'b1;
            if (m_flag[i]) m_act[i] = m_pend[i];
            m_flag[i] = 1'b0;
            m_next[i] = t_now + m_act[i];
          end
        end
        if (wr) begin
          m_pend[i] = val;
          m_flag[i] = 1'b1;
        end
      end
    end
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Cycle-by-cycle comparison against the model.
  initial begin
    logic [NCH-1:0] e_out, e_tick, e_busy;
    forever begin
      @(negedge clk);
      if (chk_on) begin
        for (int i = 0; i < NCH; i++) begin
          e_out[i]  = m_out[i];
          e_tick[i] = m_tick[i];
          e_busy[i] = m_flag[i];
        end
        vec_cnt++;
        if (clk_out !== e_out || tick !== e_tick || busy !== e_busy) begin
          mis_cnt++;
          $display("FAIL model_cmp t=%0t clk_out=%b exp=%b tick=%b exp=%b busy=%b exp=%b",
                   $time, clk_out, e_out, tick, e_tick, busy, e_busy);
        end
      end
    end
  end

  task automatic check(input string name, input longint got, input longint exp);
    vec_cnt++;
    if (got != exp) begin
      mis_cnt++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end else begin
      $display("ok   %s = %0d", name, got);
    end
  endtask

  task automatic do_wr(input int ch, input int val);
    div_wr  = 1'b1;
    div_ch  = CHW'(ch);
    div_val = CW'(val);
    @(negedge clk);
    div_wr  = 1'b0;
  endtask

  // Negedges until clk_out[ch] equals lvl; -1 if the bound expires.
  task automatic wait_lvl(input int ch, input logic lvl, output int n);
    n = -1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (clk_out[ch] == lvl) begin
        n = k;
        break;
      end
    end
  endtask

  initial begin
    int n;
    int s;
    int f[NCH];

    @(negedge clk);
    chk_on = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_clk_out", clk_out, 0);
    check("rst_tick", tick, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: program ch0 while disabled, then run
    do_wr(0, 3);
    check("s1_busy_disabled", busy[0], 0);
    en[0] = 1'b1;
    wait_lvl(0, 1'b1, n);
    check("s1_first_rise", n, 3);
    check("s1_tick_at_rise", tick[0], 1);
    wait_lvl(0, 1'b0, n);
    check("s1_half_period", n, 3);

    // 2: rewrite ch1 mid-period
    do_wr(1, 3);
    en[1] = 1'b1;
    wait_lvl(1, 1'b1, n);
    check("s2_first_rise", n, 3);
    div_wr = 1'b1; div_ch = 3'd1; div_val = 32'd5;
    @(negedge clk);
    div_wr = 1'b0;
    check("s2_busy_set", busy[1], 1);
    wait_lvl(1, 1'b0, n);
    check("s2_old_half", n, 2);
    check("s2_busy_clear", busy[1], 0);
    wait_lvl(1, 1'b1, n);
    check("s2_new_half", n, 5);

    // 3: zero divisor and out-of-range channel
    do_wr(2, 0);
    en[2] = 1'b1;
    wait_lvl(2, 1'b1, n);
    check("s3_first_rise", n, 1);
    s = 0;
    repeat (8) begin
      @(negedge clk);
      s += int'(tick[2]);
    end
    check("s3_tick_count", s, 8);
    do_wr(4, 7);
    check("s3_oob_busy", busy, 0);

    // 4: sync aligns ch0 (4) and ch1 (6)
    en[1:0] = 2'b00;
    @(negedge clk);
    do_wr(0, 4);
    do_wr(1, 6);
    en[0] = 1'b1;
    repeat (3) @(negedge clk);
    en[1] = 1'b1;
    repeat (7) @(negedge clk);
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
    check("s4_low_after_sync", clk_out[1:0], 0);
    f[0] = -1; f[1] = -1;
    for (int k = 2; k <= 20; k++) begin
      @(negedge clk);
      if (clk_out[0] && f[0] < 0) f[0] = k;
      if (clk_out[1] && f[1] < 0) f[1] = k;
    end
    check("s4_ch0_rise", f[0], 5);
    check("s4_ch1_rise", f[1], 7);

    // 5: asynchronous reset between edges
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("s5_async_clk_out", clk_out, 0);
    check("s5_async_tick", tick, 0);
    check("s5_async_busy", busy, 0);
    @(negedge clk);
    en = '1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NCH; i++) f[i] = -1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      for (int i = 0; i < NCH; i++)
        if (clk_out[i] && f[i] < 0) f[i] = k;
    end
    for (int i = 0; i < NCH; i++) check($sformatf("s5_def_rise_ch%0d", i), f[i], DEFD);

    // 6: drop and restore en[3] while high
    en[3] = 1'b0;
    @(negedge clk);
    check("s6_drop_clk_out", clk_out[3], 0);
    check("s6_drop_tick", tick[3], 0);
    en[3] = 1'b1;
    wait_lvl(3, 1'b1, n);
    check("s6_reenable_rise", n, DEFD);

    // Randomized run
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 19) == 0) en = NCH'($urandom);
      div_wr  = ($urandom_range(0, 3) == 0);
      div_ch  = CHW'($urandom_range(0, 7));
      div_val = CW'($urandom_range(0, 6));
      sync    = ($urandom_range(0, 49) == 0);
      @(negedge clk);
    end
    div_wr = 1'b0;
    sync   = 1'b0;
    repeat (20) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
    $finish;
  end

endmodule
